alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: CNT_W, default 16, width of each per-requester operation counter (used only with ALU_SCHED_STATS_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: requester i's operation accepted this cycle.
REQ-006 req0_a, req0_b  input  4 each, signed  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 opcode.
REQ-008 req1_a, req1_b  input  4 each, signed  requester 1 operands.
REQ-009 req1_op  input  3  requester 1 opcode.
REQ-010 rsp_valid  output  1  response result valid.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_id  output  1  requester that owns the response.
REQ-013 rsp_result  output  8, signed  operation result.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 op_cnt0, op_cnt1  output  CNT_W each  completed-operation counts (present only with ALU_SCHED_STATS_EN).

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid is set, grant one requester; req_ready[grant]=1 combinationally that cycle, and the other req_ready bit =0; operands, opcode and id are registered; next state EXEC.
REQ-018 Arbitration: round-robin. A sole requester is always granted. On simultaneous requests the requester other than the last-served one wins. The pointer favours requester 0 after reset.
REQ-019 req_ready = 2'b00 in EXEC and RESP, and in IDLE when req_valid = 2'b00.
REQ-020 EXEC: lasts exactly one cycle; the shared ALU evaluates the registered operands; its output is registered into rsp_result; next state RESP.
REQ-021 RESP: rsp_valid=1. rsp_result and rsp_id are held stable until rsp_ready=1. On that handshake: next state IDLE, and the last-served pointer is updated to rsp_id.
REQ-022 Latency: accept at cycle N -> rsp_valid at N+2. Maximum throughput is one operation per 3 cycles; there is no back-to-back accept during RESP.
REQ-023 Arithmetic uses an 8-bit signed context, with operands sign-extended before the operation. Opcode mapping:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 mul
  - 101 shift left by 1
  - 110 arithmetic shift right by 1
  - 111 xor
REQ-024 rsp_ready while rsp_valid=0 is ignored. Changes on req_* inputs after acceptance do not affect the in-flight result.
REQ-025 Reset asserted in EXEC or RESP discards the transaction; no response is produced.

Reset
REQ-026 While rst_n=0, at the clock edge:
  - state=IDLE
  - rsp_valid=0, rsp_result=0, rsp_id=0
  - operand registers cleared
  - round-robin pointer favours requester 0
  - counters=0
REQ-027 req_ready=2'b00 and busy=0 while rst_n=0.

Configuration
REQ-028 The macro ALU_SCHED_STATS_EN, when defined, adds op_cnt0/op_cnt1. On each response handshake, the counter selected by rsp_id increments, saturating at 2^CNT_W-1.
REQ-029 Without ALU_SCHED_STATS_EN, the counter ports and logic are absent; all other behaviour is identical.

Structure
REQ-030 The shared package alu_sched_pkg holds:
  - opcode enum (OP_ADD..OP_XOR)
  - FSM state enum
  - OPND_W=4, RES_W=8
REQ-031 The datapath is one instance of sub-module advanced_alu, fed from the operand registers; alu_sched contains no duplicate arithmetic.

Verification
REQ-032 Requester 0 alone, a=3, b=-2, op=000 -> req_ready=2'b01 at accept; rsp_valid 2 cycles later; rsp_result=1; rsp_id=0.
REQ-033 Both requesters valid after reset: req0 a=-4 b=3 op=100, req1 a=7 b=1 op=001.
  - First response: id0, result -12 (8'hF4).
  - Second response: id1, result 6.
  - Next simultaneous request: granted to requester 0.
REQ-034 Backpressure: a=-8 op=110, rsp_ready held low 5 cycles -> rsp_valid=1 with result -4 (8'hFC) stable throughout; req_ready=00; busy=1.
REQ-035 Shift edges:
  - a=7 op=101 -> 14
  - a=-8 op=101 -> -16 (8'hF0)
  - a=-1 op=110 -> -1
REQ-036 Reset pulse in EXEC -> rsp_valid never rises; outputs 0; next request a=1 b=1 op=000 -> result 2 at N+2.
REQ-037 With ALU_SCHED_STATS_EN and CNT_W=2:
  - 3 ops from requester 1 -> op_cnt1=3, op_cnt0=0.
  - 2 further ops from requester 1 -> op_cnt1 stays 3.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared opcodes, FSM states and widths for alu_sched
package alu_sched_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MUL = 3'b100,
        OP_SHL = 3'b101,
        OP_ASR = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic signed [RES_W-1:0] sext_opnd(input logic signed [OPND_W-1:0] v);
        return RES_W'(v);
    endfunction

endpackage

// File: rtl/advanced_alu.sv
// rtl/advanced_alu.sv - combinational signed ALU; operands widened to the result width first
module advanced_alu
    import alu_sched_pkg::*;
(
    input  logic signed [OPND_W-1:0] a,
    input  logic signed [OPND_W-1:0] b,
    input  logic        [2:0]        op,
    output logic signed [RES_W-1:0]  y
);

    logic signed [RES_W-1:0] ax;
    logic signed [RES_W-1:0] bx;

    always_comb begin
        ax = sext_opnd(a);
        bx = sext_opnd(b);
        y  = '0;
        case (op)
            OP_ADD:  y = ax + bx;
            OP_SUB:  y = ax - bx;
            OP_AND:  y = ax & bx;
            OP_OR:   y = ax | bx;
            OP_MUL:  y = ax * bx;
            OP_SHL:  y = ax <<< 1;
            OP_ASR:  y = ax >>> 1;
            OP_XOR:  y = ax ^ bx;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester round-robin front end for one shared ALU
// ALU_SCHED_STATS_EN adds saturating per-requester completed-operation counters.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic signed [3:0] req0_a,
    input  logic signed [3:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic signed [3:0] req1_a,
    input  logic signed [3:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic signed [7:0] rsp_result,
    output logic              busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]  op_cnt0,
    output logic [CNT_W-1:0]  op_cnt1
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("alu_sched: CNT_W must be at least 1");
    end

    state_e                  state_q, state_d;
    logic signed [OPND_W-1:0] a_q, a_d;
    logic signed [OPND_W-1:0] b_q, b_d;
    logic [2:0]              op_q, op_d;
    logic                    id_q, id_d;
    logic                    last_q, last_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic signed [RES_W-1:0] rsp_result_q, rsp_result_d;
    logic signed [RES_W-1:0] alu_y;
    logic                    grant_id;
    logic                    rsp_hs;

    advanced_alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // last_q holds the last-served id; reset value 1 makes requester 0 win the first tie.
    always_comb begin
        grant_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        req_ready = 2'b00;
        if (rst_n && state_q == ST_IDLE && req_valid != 2'b00) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
        busy   = rst_n && (state_q != ST_IDLE);
        rsp_hs = (state_q == ST_RESP) && rsp_ready;
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        last_d       = last_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                    op_d    = grant_id ? req1_op : req0_op;
                    id_d    = grant_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_y;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_q       <= last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;

`ifdef ALU_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (rsp_hs && !id_q && cnt0_q != '1) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (rsp_hs && id_q && cnt1_q != '1) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign op_cnt0 = cnt0_q;
    assign op_cnt1 = cnt1_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched
module tb_alu_sched;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic signed [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]        req0_op, req1_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [7:0]        rsp_result;
    logic              busy;
`ifdef ALU_SCHED_STATS_EN
    logic [1:0]        op_cnt0, op_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_sched #(.CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef ALU_SCHED_STATS_EN
        ,
        .op_cnt0    (op_cnt0),
        .op_cnt1    (op_cnt1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input int a, input int b, input int op);
        if (id == 0) begin
            req0_a = 4'(a); req0_b = 4'(b); req0_op = 3'(op);
        end else begin
            req1_a = 4'(a); req1_b = 4'(b); req1_op = 3'(op);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    task automatic finish_rsp(input string tag, input int id, input int res);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 1);
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, "_result"}, 32'(rsp_result), 32'(res));
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        check_eq({tag, "_done"}, 32'(rsp_valid), 0);
        check_eq({tag, "_idle"}, 32'(busy), 0);
    endtask

    // Accept, then scramble the requester's inputs to show the in-flight op is isolated.
    task automatic single_op(input string tag, input int id, input int a, input int b,
                             input int op, input int res);
        set_req(id, a, b, op);
        req_valid = (id != 0) ? 2'b10 : 2'b01;
        #1;
        check_eq({tag, "_ready"}, 32'(req_ready), (id != 0) ? 2 : 1);
        step;
        req_valid = 2'b00;
        set_req(id, int'($urandom), int'($urandom), int'($urandom));
        check_eq({tag, "_exec_valid"}, 32'(rsp_valid), 0);
        check_eq({tag, "_exec_busy"}, 32'(busy), 1);
        step;
        finish_rsp(tag, id, res);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        step;
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_busy", 32'(busy), 0);
        step;
        check_eq("rst_valid", 32'(rsp_valid), 0);
        check_eq("rst_result", 32'(rsp_result), 0);
        check_eq("rst_id", 32'(rsp_id), 0);
        do_reset;

        single_op("add", 0, 3, -2, 0, 'h01);

        // Tie-break after reset, then a sole requester, then tie again.
        do_reset;
        set_req(0, -4, 3, 4);
        set_req(1, 7, 1, 1);
        req_valid = 2'b11;
        #1;
        check_eq("rr_first_ready", 32'(req_ready), 1);
        step;
        req_valid = 2'b10;
        check_eq("rr_exec_ready", 32'(req_ready), 0);
        step;
        check_eq("rr_resp_ready", 32'(req_ready), 0);
        finish_rsp("rr_first", 0, 'hF4);
        #1;
        check_eq("rr_second_ready", 32'(req_ready), 2);
        step;
        req_valid = 2'b00;
        step;
        finish_rsp("rr_second", 1, 'h06);
        set_req(0, 2, 2, 0);
        set_req(1, 1, 1, 0);
        req_valid = 2'b11;
        #1;
        check_eq("rr_third_ready", 32'(req_ready), 1);
        step;
        req_valid = 2'b00;
        step;
        finish_rsp("rr_third", 0, 'h04);

        set_req(0, -8, 0, 6);
        req_valid = 2'b01;
        step;
        req_valid = 2'b00;
        step;
        for (int i = 0; i < 5; i++) begin
            req_valid = 2'b11;
            #1;
            check_eq("bp_valid", 32'(rsp_valid), 1);
            check_eq("bp_result", 32'(rsp_result), 'hFC);
            check_eq("bp_ready", 32'(req_ready), 0);
            check_eq("bp_busy", 32'(busy), 1);
            step;
        end
        req_valid = 2'b00;
        finish_rsp("bp", 0, 'hFC);

        single_op("shl_pos", 1, 7, 0, 5, 'h0E);
        single_op("shl_neg", 0, -8, 0, 5, 'hF0);
        single_op("asr_m1", 1, -1, 0, 6, 'hFF);
        single_op("and", 0, 5, -3, 2, 'h05);
        single_op("or", 1, 5, -3, 3, 'hFD);
        single_op("xor", 0, 5, -3, 7, 'hF8);
        single_op("mul_max", 1, -8, -8, 4, 'h40);
        single_op("sub_neg", 0, -8, 7, 1, 'hF1);

        // Reset while the op is in EXEC must drop it entirely.
        set_req(0, 5, 5, 0);
        req_valid = 2'b01;
        step;
        req_valid = 2'b00;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        check_eq("rstx_valid", 32'(rsp_valid), 0);
        check_eq("rstx_result", 32'(rsp_result), 0);
        check_eq("rstx_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            step;
            check_eq("rstx_quiet", 32'(rsp_valid), 0);
        end
        single_op("rstx_next", 0, 1, 1, 0, 'h02);

`ifdef ALU_SCHED_STATS_EN
        do_reset;
        for (int i = 0; i < 3; i++) single_op("cnt_a", 1, i, 1, 0, i + 1);
        check_eq("cnt1_three", 32'(op_cnt1), 3);
        check_eq("cnt0_zero", 32'(op_cnt0), 0);
        for (int i = 0; i < 2; i++) single_op("cnt_b", 1, 1, 1, 2, 1);
        check_eq("cnt1_sat", 32'(op_cnt1), 3);
        check_eq("cnt0_still", 32'(op_cnt0), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
